wb_seq_master: RTL and testbench

Wishbone classic-cycle initiator for the user area. It turns single-word or fixed-length incrementing commands, issued by local logic or LA-driven control, into Wishbone bus cycles toward user-area slaves such as the counter peripheral. Each beat returns a response carrying read data and a termination status. A bounded ack timeout guarantees forward progress when a slave never responds.

---
 rtl/wb_seq_master.sv | 126 ++++++++++++
 tb/tb_wb_seq_master.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_seq_master.sv
// Wishbone classic-cycle initiator: turns single or incrementing-burst commands into
// bus beats and returns one response per beat, with an ack timeout for silent slaves.
module wb_seq_master #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rstn_i,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_adr,
   input  logic [31:0] cmd_dat,
   input  logic [3:0]  cmd_sel,
   input  logic        cmd_we,
   input  logic [7:0]  cmd_len,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_dat,
   output logic        rsp_err,
   output logic        rsp_last,
   output logic        busy,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i
);

   localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t          state;
   logic [7:0]      remaining;
   logic [TW-1:0]   tmo_cnt;
   logic            tmo_hit;
   logic            unused_adr_lsb;

   assign unused_adr_lsb = ^cmd_adr[1:0];
   assign tmo_hit        = (TIMEOUT != 0) && (tmo_cnt == TW'(TIMEOUT));
   assign wbm_stb_o      = wbm_cyc_o;

   // cmd_ready is registered so it reads 0 throughout reset and rises one edge after release.
   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         state     <= IDLE;
         remaining <= '0;
         tmo_cnt   <= '0;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_dat   <= '0;
         rsp_err   <= 1'b0;
         rsp_last  <= 1'b0;
         busy      <= 1'b0;
         wbm_cyc_o <= 1'b0;
         wbm_we_o  <= 1'b0;
         wbm_sel_o <= '0;
         wbm_adr_o <= '0;
         wbm_dat_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  wbm_adr_o <= {cmd_adr[31:2], 2'b00};
                  wbm_dat_o <= cmd_dat;
                  wbm_sel_o <= cmd_sel;
                  wbm_we_o  <= cmd_we;
                  remaining <= cmd_len;
                  tmo_cnt   <= '0;
                  wbm_cyc_o <= 1'b1;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= BUS;
               end else begin
                  cmd_ready <= 1'b1;
               end
            end
            BUS: begin
               tmo_cnt <= tmo_cnt + TW'(1);
               // err outranks a simultaneous ack; either error path aborts the command
               if (wbm_err_i || tmo_hit) begin
                  rsp_dat   <= '0;
                  rsp_err   <= 1'b1;
                  rsp_last  <= 1'b1;
                  rsp_valid <= 1'b1;
                  wbm_cyc_o <= 1'b0;
                  state     <= RESP;
               end else if (wbm_ack_i) begin
                  rsp_dat   <= wbm_we_o ? '0 : wbm_dat_i;
                  rsp_err   <= 1'b0;
                  rsp_last  <= (remaining == 8'd0);
                  rsp_valid <= 1'b1;
                  wbm_cyc_o <= 1'b0;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (rsp_last) begin
                     busy      <= 1'b0;
                     cmd_ready <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     wbm_adr_o <= wbm_adr_o + 32'd4;
                     remaining <= remaining - 8'd1;
                     tmo_cnt   <= '0;
                     wbm_cyc_o <= 1'b1;
                     state     <= BUS;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               wbm_cyc_o <= 1'b0;
               rsp_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_seq_master.sv
// Randomized bench for wb_seq_master: a bench-driven slave plus a per-command reference
// of expected beat addresses and responses.
module tb_wb_seq_master;

   localparam int unsigned TMO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_adr, cmd_dat;
   logic [3:0]  cmd_sel;
   logic [7:0]  cmd_len;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_last, busy;
   logic [31:0] rsp_dat;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
   logic        wbm_ack_i, wbm_err_i;

   int total = 0;
   int bad   = 0;

   wb_seq_master #(.TIMEOUT(TMO)) dut (
      .wb_clk_i (clk),       .wb_rstn_i(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_adr  (cmd_adr),   .cmd_dat  (cmd_dat),
      .cmd_sel  (cmd_sel),   .cmd_we   (cmd_we),
      .cmd_len  (cmd_len),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_dat  (rsp_dat),   .rsp_err  (rsp_err),
      .rsp_last (rsp_last),  .busy     (busy),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
      .wbm_we_o (wbm_we_o),  .wbm_sel_o(wbm_sel_o),
      .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
      .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
      .wbm_err_i(wbm_err_i)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // abort_beat < 0: no abort. silent selects timeout instead of err on the abort beat.
   task automatic do_cmd(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic we, input int len, input int abort_beat, input bit silent,
                         input logic [31:0] rdata0, input int bp);
      logic [31:0] base, exp_adr, rd, e_dat;
      logic        e_err, e_last, ab;
      int          cnt, lat;
      @(negedge clk);
      check_eq("idle_ready", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
      cmd_we = we; cmd_len = 8'(len);
      @(negedge clk);
      cmd_valid = 1'b0; cmd_adr = $urandom; cmd_dat = $urandom;
      cmd_sel = 4'($urandom); cmd_we = ~we; cmd_len = 8'($urandom);
      base = {adr[31:2], 2'b00};
      for (int b = 0; b <= len; b++) begin
         exp_adr = base + 32'(b) * 32'd4;
         wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
         check_eq("bus_cyc", wbm_cyc_o, 1);
         check_eq("bus_stb", wbm_stb_o, 1);
         check_eq("bus_adr", wbm_adr_o, exp_adr);
         check_eq("bus_we", wbm_we_o, we);
         check_eq("bus_dat", wbm_dat_o, dat);
         check_eq("bus_sel", wbm_sel_o, sel);
         check_eq("bus_busy", busy, 1);
         check_eq("bus_cmd_ready", cmd_ready, 0);
         rd = rdata0 + 32'(b);
         ab = (b == abort_beat);
         if (ab && silent) begin
            cnt = 0;
            while (wbm_cyc_o === 1'b1 && cnt < 300) begin
               cnt++;
               @(negedge clk);
            end
            check_eq("tmo_stb_cycles", cnt, TMO + 1);
         end else begin
            lat = $urandom_range(0, 2);
            repeat (lat) begin
               @(negedge clk);
               check_eq("wait_cyc", wbm_cyc_o, 1);
            end
            wbm_dat_i = rd;
            if (ab) begin
               wbm_err_i = 1'b1;
               wbm_ack_i = 1'($urandom_range(0, 1));
            end else begin
               wbm_ack_i = 1'b1;
            end
            @(negedge clk);
            wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = $urandom;
         end
         e_dat  = (ab || we) ? 32'd0 : rd;
         e_err  = ab;
         e_last = ab || (b == len);
         check_eq("rsp_valid", rsp_valid, 1);
         check_eq("rsp_cyc_low", wbm_cyc_o, 0);
         check_eq("rsp_dat", rsp_dat, e_dat);
         check_eq("rsp_err", rsp_err, e_err);
         check_eq("rsp_last", rsp_last, e_last);
         for (int k = 0; k < bp; k++) begin
            wbm_ack_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("bp_valid", rsp_valid, 1);
            check_eq("bp_cyc_low", wbm_cyc_o, 0);
            check_eq("bp_dat", rsp_dat, e_dat);
            check_eq("bp_err", rsp_err, e_err);
            check_eq("bp_last", rsp_last, e_last);
         end
         wbm_ack_i = 1'b0;
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
         if (e_last) break;
      end
      check_eq("done_ready", cmd_ready, 1);
      check_eq("done_busy", busy, 0);
      check_eq("done_valid", rsp_valid, 0);
      repeat (3) begin
         @(negedge clk);
         check_eq("no_extra_cyc", wbm_cyc_o, 0);
         check_eq("no_extra_rsp", rsp_valid, 0);
      end
   endtask

   task automatic reset_mid_burst();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_adr = 32'h3000_0010; cmd_dat = 32'h0; cmd_sel = 4'hF;
      cmd_we = 1'b0; cmd_len = 8'd3;
      @(negedge clk);
      cmd_valid = 1'b0;
      wbm_ack_i = 1'b1; wbm_dat_i = 32'h1234_5678;
      @(negedge clk);
      wbm_ack_i = 1'b0;
      check_eq("rst_beat1_dat", rsp_dat, 32'h1234_5678);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check_eq("rst_beat2_cyc", wbm_cyc_o, 1);
      check_eq("rst_beat2_adr", wbm_adr_o, 32'h3000_0014);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_async_cyc", wbm_cyc_o, 0);
      check_eq("rst_async_stb", wbm_stb_o, 0);
      check_eq("rst_async_valid", rsp_valid, 0);
      check_eq("rst_async_busy", busy, 0);
      check_eq("rst_async_ready", cmd_ready, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst_rel_ready", cmd_ready, 1);
      check_eq("rst_rel_valid", rsp_valid, 0);
      check_eq("rst_rel_busy", busy, 0);
      check_eq("rst_rel_cyc", wbm_cyc_o, 0);
   endtask

   initial begin
      int len, abort_beat;
      cmd_valid = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0; cmd_we = 1'b0; cmd_len = '0;
      rsp_ready = 1'b0; wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("reset_ready", cmd_ready, 0);
      check_eq("reset_cyc", wbm_cyc_o, 0);
      check_eq("reset_valid", rsp_valid, 0);
      check_eq("reset_busy", busy, 0);
      check_eq("reset_adr", wbm_adr_o, 0);
      rst_n = 1'b1;
      @(negedge clk);

      do_cmd(32'h3000_0003, $urandom, 4'hF, 1'b0, 0, -1, 1'b0, 32'hCAFE_F00D, 0);
      do_cmd(32'h3000_0000, 32'hA5A5_A5A5, 4'hF, 1'b1, 3, -1, 1'b0, $urandom, 0);
      do_cmd(32'h3000_0020, $urandom, 4'h3, 1'b0, 1, -1, 1'b0, $urandom, 5);
      do_cmd(32'h3000_0040, $urandom, 4'hF, 1'b0, 2, 1, 1'b0, $urandom, 0);
      do_cmd(32'h3000_0080, $urandom, 4'hF, 1'b0, 2, 0, 1'b1, $urandom, 0);
      do_cmd(32'hFFFF_FFFC, $urandom, 4'hC, 1'b0, 1, -1, 1'b0, $urandom, 1);
      reset_mid_burst();

      for (int i = 0; i < 40; i++) begin
         len = $urandom_range(0, 5);
         abort_beat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
         do_cmd($urandom, $urandom, 4'($urandom), 1'($urandom_range(0, 1)), len, abort_beat,
                1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
